// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and loads IF/ID.
// Optional performance counters are enabled with `define IFETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        pcsrc_d,
  input  logic [31:0] pcbranch_d,
  input  logic        jump_d,
  input  logic [31:0] pcjump_d,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic [5:0]  opcode_d,
  output logic [5:0]  funct_d,
  output logic        fetch_busy
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_wait
`endif
);

  localparam logic [31:0] PC_RST = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        done;
  logic [31:0] pc_plus4;
  logic        load_fetch;
  logic        load_skid;
  logic        accept;

  assign imem_req   = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign fetch_busy = imem_req & ~imem_ack;

  assign instr_d   = ifid_instr_q;
  assign pcplus4_d = ifid_pc4_q;
  assign valid_d   = ifid_valid_q;
  assign opcode_d  = ifid_instr_q[31:26];
  assign funct_d   = ifid_instr_q[5:0];

  always_comb begin
    redirect   = ~stall_d & (pcsrc_d | jump_d);
    target_raw = pcsrc_d ? pcbranch_d : pcjump_d;
    target     = target_raw & ~32'h3;
    done       = imem_req & imem_ack;
    pc_plus4   = pc_q + 32'd4;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    load_fetch   = 1'b0;
    load_skid    = 1'b0;
    accept       = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          // An unacked request must stay on the bus; park its address and drain it.
          if (!done) begin
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
        end else if (done) begin
          accept = 1'b1;
          pc_d   = pc_plus4;
          if (stall_d) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            state_d      = S_HOLD;
          end else begin
            load_fetch = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (done) state_d = S_FETCH;
      end
      S_HOLD: begin
        if (!stall_d) begin
          state_d = S_FETCH;
          if (!redirect) load_skid = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      pc_d         = target;
      skid_instr_d = '0;
      skid_pc4_d   = '0;
    end

    if (redirect) begin
      ifid_instr_d = '0;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (load_fetch) begin
      ifid_instr_d = imem_rdata;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end else if (load_skid) begin
      ifid_instr_d = skid_instr_q;
      ifid_pc4_d   = skid_pc4_q;
      ifid_valid_d = 1'b1;
    end else if (!stall_d) begin
      ifid_instr_d = '0;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RST;
      drain_addr_q <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_wait_d  = perf_wait_q;
    if (accept)     perf_fetch_d = perf_fetch_q + 32'd1;
    if (fetch_busy) perf_wait_d  = perf_wait_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_wait  = perf_wait_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
